// File: rtl/conv_stream.sv
// conv_stream: streaming SIZE x SIZE valid 2-D convolution, raster in/out.
// Define CONV_RELU_EN to clamp negative results to zero.
module conv_stream #(
  parameter int SIZE      = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IMG_W     = 16,
  parameter int IMG_H     = 16,
  parameter int SHIFT     = 0
) (
  input  logic                         clock,
  input  logic                         nreset,
  input  logic                         ena,
  input  logic                         k_we,
  input  logic [$clog2(SIZE*SIZE)-1:0] k_addr,
  input  logic signed [WIDTH_BIT-1:0]  k_data,
  input  logic                         pix_valid,
  input  logic signed [WIDTH_BIT-1:0]  pix_data,
  output logic                         pix_ready,
  output logic                         out_valid,
  output logic signed [WIDTH_BIT-1:0]  out_data,
  input  logic                         out_ready,
  output logic                         frame_done
);
  localparam int N  = SIZE * SIZE;
  localparam int W  = WIDTH_BIT;
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + $clog2(N);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(SIZE - 1);
  localparam logic signed [AW-1:0] MAXV =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic frame_done_q, frame_done_d;
  logic signed [W-1:0] k_q [N];
  logic signed [W-1:0] k_d [N];
  logic signed [W-1:0] win_q [SIZE][SIZE];
  logic signed [W-1:0] win_d [SIZE][SIZE];
  logic signed [W-1:0] lb_q [SIZE-1][IMG_W];
  logic signed [W-1:0] lb_d [SIZE-1][IMG_W];
  logic win_v_q, win_v_d;
  logic signed [PW-1:0] prod_q [N];
  logic signed [PW-1:0] prod_d [N];
  logic p_v_q, p_v_d;
  logic out_v_q, out_v_d;
  logic signed [W-1:0] out_q, out_d;

  logic stall, accept, complete, last_pix;
  logic signed [AW-1:0] acc_c, sh_c;
  logic signed [W-1:0] res_c;

  assign stall      = out_v_q && !out_ready;
  assign pix_ready  = (state_q == RUN) && !stall;
  assign accept     = pix_valid && pix_ready;
  assign complete   = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign out_valid  = out_v_q;
  assign out_data   = out_q;
  assign frame_done = frame_done_q;

  // Frame sequencing: raster counters and IDLE/RUN/DRAIN control.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: if (ena) begin
        state_d = RUN;
        row_d   = '0;
        col_d   = '0;
      end
      RUN: if (accept) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
        if (last_pix) state_d = DRAIN;
      end
      DRAIN: if (!win_v_q && !p_v_q && out_v_q && out_ready) begin
        state_d      = IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Kernel writes are only honoured while idle and in range.
  always_comb begin
    k_d = k_q;
    if (state_q == IDLE && k_we && 32'(k_addr) < N)
      k_d[k_addr] = k_data;
  end

  // Shift a new column into the window; rotate the line buffers.
  always_comb begin
    win_d = win_q;
    lb_d  = lb_q;
    if (accept) begin
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE - 1; j++)
          win_d[i][j] = win_q[i][j+1];
      for (int i = 0; i < SIZE - 1; i++)
        win_d[i][SIZE-1] = lb_q[SIZE-2-i][col_q];
      win_d[SIZE-1][SIZE-1] = pix_data;
      lb_d[0][col_q] = pix_data;
      for (int k = 1; k < SIZE - 1; k++)
        lb_d[k][col_q] = lb_q[k-1][col_q];
    end
  end

  // Exact sum of products, shift, saturate (and optional ReLU).
  always_comb begin
    acc_c = '0;
    for (int k = 0; k < N; k++)
      acc_c = acc_c + AW'(prod_q[k]);
    sh_c = acc_c >>> SHIFT;
    if (sh_c > MAXV)      res_c = MAXV[W-1:0];
    else if (sh_c < MINV) res_c = MINV[W-1:0];
    else                  res_c = sh_c[W-1:0];
`ifdef CONV_RELU_EN
    if (res_c[W-1]) res_c = '0;
`else
    res_c = res_c;
`endif
  end

  // Pipeline advance: everything holds while the output is blocked.
  always_comb begin
    win_v_d = win_v_q;
    p_v_d   = p_v_q;
    prod_d  = prod_q;
    out_v_d = out_v_q;
    out_d   = out_q;
    if (!stall) begin
      win_v_d = accept && complete;
      p_v_d   = win_v_q;
      if (win_v_q)
        for (int i = 0; i < SIZE; i++)
          for (int j = 0; j < SIZE; j++)
            prod_d[i*SIZE+j] = PW'(win_q[i][j]) * PW'(k_q[i*SIZE+j]);
      out_v_d = p_v_q;
      if (p_v_q) out_d = res_c;
    end
  end

  // State registers with asynchronous clear of all storage.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      win_v_q      <= 1'b0;
      p_v_q        <= 1'b0;
      out_v_q      <= 1'b0;
      out_q        <= '0;
      for (int k = 0; k < N; k++) begin
        k_q[k]    <= '0;
        prod_q[k] <= '0;
      end
      for (int i = 0; i < SIZE; i++)
        for (int j = 0; j < SIZE; j++)
          win_q[i][j] <= '0;
      for (int i = 0; i < SIZE - 1; i++)
        for (int j = 0; j < IMG_W; j++)
          lb_q[i][j] <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      win_v_q      <= win_v_d;
      p_v_q        <= p_v_d;
      out_v_q      <= out_v_d;
      out_q        <= out_d;
      k_q          <= k_d;
      prod_q       <= prod_d;
      win_q        <= win_d;
      lb_q         <= lb_d;
    end
  end
endmodule

// File: tb/tb_conv_stream.sv
// tb_conv_stream: scoreboard bench for conv_stream, 3x3 kernel, 5x5 image.
// A SHIFT=0 and a SHIFT=3 instance share every input.
module tb_conv_stream;
  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic ena = 1'b0;
  logic k_we = 1'b0;
  logic [3:0] k_addr = '0;
  logic signed [7:0] k_data = '0;
  logic pix_valid = 1'b0;
  logic signed [7:0] pix_data = '0;
  logic out_ready = 1'b1;
  logic pix_ready, out_valid, frame_done;
  logic signed [7:0] out_data;
  logic pix_ready3, out_valid3, frame_done3;
  logic signed [7:0] out_data3;

  int total = 0;
  int bad = 0;
  int img [25];
  logic signed [7:0] kern [9];
  logic [7:0] q [$];
  logic [7:0] q3 [$];
  logic [7:0] got [$];
  logic [7:0] got3 [$];
  int exp30 [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};

  always #5 clock = ~clock;

  conv_stream #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(5), .IMG_H(5),
                .SHIFT(0)) dut (
    .clock(clock), .nreset(nreset), .ena(ena), .k_we(k_we),
    .k_addr(k_addr), .k_data(k_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .frame_done(frame_done));

  conv_stream #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(5), .IMG_H(5),
                .SHIFT(3)) dut3 (
    .clock(clock), .nreset(nreset), .ena(ena), .k_we(k_we),
    .k_addr(k_addr), .k_data(k_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready3),
    .out_valid(out_valid3), .out_data(out_data3),
    .out_ready(out_ready), .frame_done(frame_done3));

  function automatic logic [7:0] model(int r, int c, int sh);
    int acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += img[(r+i)*5 + c + j] * int'(kern[i*3 + j]);
    acc = acc >>> sh;
    if (acc > 127) acc = 127;
    else if (acc < -128) acc = -128;
`ifdef CONV_RELU_EN
    if (acc < 0) acc = 0;
`endif
    return 8'(acc);
  endfunction

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      k_we = 1'b1;
      k_addr = 4'(i);
      k_data = kern[i];
    end
    @(negedge clock);
    k_we = 1'b0;
  endtask

  task automatic run_frame(input int stall_len, input int kwe_cyc,
                           input bit keep_ena);
    int idx = 0;
    int outs = 0;
    int outs3 = 0;
    int cyc = 0;
    int stall_left = stall_len;
    int r, c;
    bit a_pix, a_out, a_out3;
    bit stall_on = 1'b0;
    bit first = 1'b1;
    logic [7:0] held = '0;
    logic [7:0] e;
    q.delete(); q3.delete(); got.delete(); got3.delete();
    ena = 1'b1;
    @(posedge clock);
    #1 ena = keep_ena;
    while (outs < 9 && cyc < 500) begin
      @(negedge clock);
      k_we = (cyc == kwe_cyc);
      k_addr = 4'd4;
      k_data = 8'sd5;
      if (stall_left > 0 && outs >= 3 &&
          (stall_on || out_valid === 1'b1)) begin
        stall_on = 1'b1;
        stall_left--;
        out_ready = 1'b0;
      end else begin
        stall_on = 1'b0;
        out_ready = 1'b1;
      end
      pix_valid = (idx < 25);
      if (idx < 25) pix_data = 8'(img[idx]);
      else pix_data = '0;
      #1;
      if (stall_on) begin
        total++;
        if (pix_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_pix_ready got=%b want=0", pix_ready);
        end
        if (first) begin
          held = out_data;
          first = 1'b0;
        end else begin
          total++;
          if (out_data !== held) begin
            bad++;
            $display("FAIL stall_hold got=%h want=%h", out_data, held);
          end
        end
      end
      a_pix = pix_valid && pix_ready;
      a_out = out_valid && out_ready;
      a_out3 = out_valid3 && out_ready;
      if (a_pix) begin
        r = idx / 5;
        c = idx % 5;
        if (r >= 2 && c >= 2) begin
          q.push_back(model(r - 2, c - 2, 0));
          q3.push_back(model(r - 2, c - 2, 3));
        end
      end
      if (a_out) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL out_extra got=%h want=none", out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e) begin
            bad++;
            $display("FAIL out_data got=%h want=%h", out_data, e);
          end
        end
        got.push_back(out_data);
        outs++;
      end
      if (a_out3) begin
        total++;
        if (q3.size() == 0) begin
          bad++;
          $display("FAIL out3_extra got=%h want=none", out_data3);
        end else begin
          e = q3.pop_front();
          if (out_data3 !== e) begin
            bad++;
            $display("FAIL out3_data got=%h want=%h", out_data3, e);
          end
        end
        got3.push_back(out_data3);
        outs3++;
      end
      @(posedge clock);
      if (a_pix) idx++;
      cyc++;
    end
    pix_valid = 1'b0;
    out_ready = 1'b1;
    k_we = 1'b0;
    total++;
    if (outs != 9) begin
      bad++;
      $display("FAIL frame_timeout got=%0d want=9", outs);
    end
    @(negedge clock);
    #1;
    total++;
    if (frame_done !== 1'b1 || frame_done3 !== 1'b1) begin
      bad++;
      $display("FAIL frame_done got=%b%b want=11", frame_done, frame_done3);
    end
    total++;
    if (pix_ready !== 1'b0 || pix_ready3 !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready got=%b%b want=00", pix_ready, pix_ready3);
    end
    total++;
    if (outs3 != 9 || q.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d/%0d/%0d want=9/0/0",
               outs3, q.size(), q3.size());
    end
    @(negedge clock);
    #1;
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL frame_done_pulse got=%b want=0", frame_done);
    end
    total++;
    if (pix_ready !== keep_ena) begin
      bad++;
      $display("FAIL next_ready got=%b want=%b", pix_ready, keep_ena);
    end
  endtask

  task automatic set_center();
    foreach (kern[i]) kern[i] = (i == 4) ? 8'sd1 : 8'sd0;
    foreach (img[i]) img[i] = i;
  endtask

  task automatic check_exp30(input string tag);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (got[i] !== 8'(exp30[i])) begin
        bad++;
        $display("FAIL %s_seq%0d got=%0d want=%0d",
                 tag, i, got[i], exp30[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'sd0 ||
        pix_ready !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs got=%b%h%b%b want=0000",
               out_valid, out_data, pix_ready, frame_done);
    end
    @(negedge clock);
    nreset = 1'b1;
  endtask

  task automatic test_center();
    set_center();
    load_kernel();
    run_frame(0, -1, 1'b0);
    check_exp30("center");
  endtask

  task automatic test_saturate();
    foreach (kern[i]) kern[i] = 8'sd1;
    foreach (img[i]) img[i] = 100;
    load_kernel();
    run_frame(0, -1, 1'b0);
    total++;
    if (got[0] !== 8'd127 || got3[0] !== 8'd112) begin
      bad++;
      $display("FAIL saturate got=%0d/%0d want=127/112", got[0], got3[0]);
    end
  endtask

  task automatic test_negative();
    logic [7:0] w0, w3;
`ifdef CONV_RELU_EN
    w0 = 8'h00;
    w3 = 8'h00;
`else
    w0 = 8'hA6;
    w3 = 8'hF4;
`endif
    foreach (kern[i]) kern[i] = -8'sd1;
    foreach (img[i]) img[i] = 10;
    load_kernel();
    run_frame(0, -1, 1'b0);
    total++;
    if (got[8] !== w0 || got3[8] !== w3) begin
      bad++;
      $display("FAIL negative got=%h/%h want=%h/%h",
               got[8], got3[8], w0, w3);
    end
  endtask

  task automatic test_stall();
    set_center();
    load_kernel();
    run_frame(5, -1, 1'b0);
    check_exp30("stall");
  endtask

  task automatic test_kwe_run();
    set_center();
    load_kernel();
    run_frame(0, 10, 1'b0);
    check_exp30("kwe");
  endtask

  task automatic test_back_to_back();
    set_center();
    load_kernel();
    run_frame(0, -1, 1'b1);
    check_exp30("b2b_a");
    run_frame(0, -1, 1'b0);
    check_exp30("b2b_b");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int cyc = 0;
    int stale = 0;
    bit a;
    set_center();
    load_kernel();
    ena = 1'b1;
    @(posedge clock);
    #1 ena = 1'b0;
    while (n < 12 && cyc < 100) begin
      @(negedge clock);
      pix_valid = 1'b1;
      pix_data = 8'(img[n]);
      #1 a = pix_ready;
      @(posedge clock);
      if (a) n++;
      cyc++;
    end
    @(negedge clock);
    pix_valid = 1'b0;
    nreset = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'sd0 ||
        pix_ready !== 1'b0 || frame_done !== 1'b0 || n != 12) begin
      bad++;
      $display("FAIL midreset got=%b%h%b%b n=%0d want=0000 n=12",
               out_valid, out_data, pix_ready, frame_done, n);
    end
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    repeat (6) begin
      @(negedge clock);
      #1;
      if (out_valid !== 1'b0 || pix_ready !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL post_reset_idle got=%0d want=0", stale);
    end
    foreach (kern[i]) kern[i] = 8'sd0;
    run_frame(0, -1, 1'b0);
    total++;
    if (got[4] !== 8'd0) begin
      bad++;
      $display("FAIL kernel_cleared got=%0d want=0", got[4]);
    end
    set_center();
    load_kernel();
    run_frame(0, -1, 1'b0);
    check_exp30("rerun");
  endtask

  initial begin
    test_reset();
    test_center();
    test_saturate();
    test_negative();
    test_stall();
    test_kwe_run();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
